// File: rtl/mem_bus_arbiter.sv
// Purpose : shares one memory port between instruction fetch (IF) and data (DM); DM wins ties.
// Latency : req -> mem_req 1 cycle; mem_ready -> if_/dm_ready 1 cycle; one IDLE cycle between transfers.
// Backpr. : requests are held by the requester until its ready pulse; a watchdog aborts a stalled memory.
//
// Ports   : clk, reset_n (async active-low)
//           if_req/if_addr -> if_ready/if_rdata          instruction fetch (read only)
//           dm_req/dm_we/dm_addr/dm_wdata/dm_be -> dm_ready/dm_rdata   load/store
//           mem_req/mem_we/mem_addr/mem_wdata/mem_be <- mem_ready/mem_rdata   shared memory
//           bus_err                                       pulses with the owner's ready on abort
// Options : define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests.
module mem_bus_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_ready,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0] dm_wdata,
   input  logic [3:0]            dm_be,
   output logic                  dm_ready,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_be,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  bus_err
);

   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
   // Abort on the edge where the watchdog would reach TIMEOUT_CYCLES.
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
   localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

   state_t         state, state_nxt;
   logic [WDW-1:0] wdog;
   logic           grant_dm;
   logic           start, done, abort;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_grant_dm;   // 0 = IF won last, 1 = DM won last

   // On a tie the port that did not win last time is granted.
   assign grant_dm = dm_req & ~(if_req & last_grant_dm);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_dm <= 1'b0;
      end else if (start) begin
         last_grant_dm <= grant_dm;
      end
   end
`else
   assign grant_dm = dm_req;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      done      = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (if_req || dm_req) begin
               start     = 1'b1;
               state_nxt = grant_dm ? BUSY_DM : BUSY_IF;
            end
         end
         BUSY_IF, BUSY_DM: begin
            if (mem_ready) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end else if (wdog == WD_LAST) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= 4'h0;
         if_ready  <= 1'b0;
         if_rdata  <= '0;
         dm_ready  <= 1'b0;
         dm_rdata  <= '0;
         bus_err   <= 1'b0;
         wdog      <= '0;
      end else begin
         if_ready <= 1'b0;
         dm_ready <= 1'b0;
         bus_err  <= 1'b0;
         if (start) begin
            // Latched copy is what the memory sees for the whole transfer.
            mem_req   <= 1'b1;
            mem_we    <= grant_dm & dm_we;
            mem_addr  <= grant_dm ? dm_addr  : if_addr;
            mem_wdata <= grant_dm ? dm_wdata : '0;
            mem_be    <= grant_dm ? dm_be    : 4'hF;
            wdog      <= '0;
         end else if (done || abort) begin
            mem_req <= 1'b0;
            wdog    <= '0;
            bus_err <= abort;
            if (state == BUSY_IF) begin
               if_ready <= 1'b1;
               if_rdata <= done ? mem_rdata : '0;
            end else begin
               dm_ready <= 1'b1;
               dm_rdata <= done ? mem_rdata : '0;
            end
         end else if (state != IDLE) begin
            wdog <= (wdog == WD_MAX) ? wdog : wdog + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        if_req, if_ready;
   logic [31:0] if_addr, if_rdata;
   logic        dm_req, dm_we, dm_ready;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic [3:0]  dm_be;
   logic        mem_req, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        bus_err;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic        ifr;
      logic        dmr;
      logic        err;
      logic [31:0] rdata;
   } cpl_t;

   cpl_t exp_q[$];
   cpl_t obs_q[$];

   int mem_lat   = 0;
   bit mem_never = 1'b0;
   bit stray     = 1'b0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
      .dm_ready(dm_ready), .dm_rdata(dm_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_err(bus_err)
   );

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return (a == 32'h10) ? 32'h0070_0393 : {a[15:0], ~a[15:0]};
   endfunction

   // Memory model: answers mem_lat cycles after it first sees mem_req.
   initial begin
      int cnt;
      cnt       = 0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_ready = stray;
         if (stray) mem_rdata = $urandom;
         if (mem_req && !mem_never) begin
            cnt++;
            if (cnt > mem_lat) begin
               mem_ready = 1'b1;
               mem_rdata = mem_val(mem_addr);
               cnt       = 0;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Completion monitor: records every ready/bus_err pulse for the scoreboard.
   always @(negedge clk) begin
      if (reset_n && (if_ready || dm_ready || bus_err))
         obs_q.push_back('{if_ready, dm_ready, bus_err, dm_ready ? dm_rdata : if_rdata});
   end

   task automatic test_reset();
      #3;
      total++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_ready, dm_ready,
           if_rdata, dm_rdata, bus_err} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: mem_req=%b mem_addr=%h if_ready=%b dm_ready=%b bus_err=%b, all must be 0",
                  mem_req, mem_addr, if_ready, dm_ready, bus_err);
      end
      @(negedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk); #1;
      total++;
      if (mem_req !== 1'b0) begin
         bad++;
         $display("FAIL idle_no_req: mem_req=%b required 0", mem_req);
      end
   endtask

   task automatic test_if_only();
      cpl_t o, e;
      int   n;
      mem_lat = 1;
      exp_q.push_back('{1'b1, 1'b0, 1'b0, 32'h0070_0393});
      if_addr = 32'h10;
      if_req  = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h10}) begin
         bad++;
         $display("FAIL if_issue: req=%b we=%b be=%h addr=%h required 1 0 f 00000010",
                  mem_req, mem_we, mem_be, mem_addr);
      end
      n = 0;
      while (obs_q.size() == 0 && n < 20) begin @(negedge clk); #1; n++; end
      if_req = 1'b0;
      total++;
      if (obs_q.size() == 0) begin
         bad++; exp_q.delete();
         $display("FAIL if_done: no completion seen, required if_ready");
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o !== e) begin
            bad++;
            $display("FAIL if_done: got ifr=%b dmr=%b err=%b rdata=%h required ifr=%b dmr=%b err=%b rdata=%h",
                     o.ifr, o.dmr, o.err, o.rdata, e.ifr, e.dmr, e.err, e.rdata);
         end
      end
      @(negedge clk); #1;
      total++;
      if (obs_q.size() != 0 || mem_req !== 1'b0) begin
         bad++;
         $display("FAIL if_single_pulse: extra=%0d mem_req=%b required 0 0", obs_q.size(), mem_req);
         obs_q.delete();
      end
   endtask

   task automatic test_dm_write();
      cpl_t o, e;
      int   n;
      mem_lat  = 2;
      exp_q.push_back('{1'b0, 1'b1, 1'b0, mem_val(32'h100)});
      dm_we    = 1'b1;
      dm_addr  = 32'h100;
      dm_wdata = 32'h22;
      dm_be    = 4'h1;
      dm_req   = 1'b1;
      n = 0;
      while (obs_q.size() == 0 && n < 20) begin
         @(negedge clk); #1; n++;
         if (mem_req) begin
            total++;
            if ({mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h100, 32'h22, 4'h1}) begin
               bad++;
               $display("FAIL dm_busy_fields: we=%b addr=%h wdata=%h be=%h required 1 00000100 00000022 1",
                        mem_we, mem_addr, mem_wdata, mem_be);
            end
         end
      end
      dm_req = 1'b0;
      dm_we  = 1'b0;
      total++;
      if (obs_q.size() == 0) begin
         bad++; exp_q.delete();
         $display("FAIL dm_done: no completion seen, required dm_ready");
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o !== e) begin
            bad++;
            $display("FAIL dm_done: got ifr=%b dmr=%b err=%b rdata=%h required ifr=%b dmr=%b err=%b rdata=%h",
                     o.ifr, o.dmr, o.err, o.rdata, e.ifr, e.dmr, e.err, e.rdata);
         end
      end
   endtask

   task automatic test_priority();
      cpl_t o, e;
      int   n;
      bit   first_dm;
      logic [31:0] second_addr;
`ifdef ARB_ROUND_ROBIN_EN
      first_dm = 1'b0;   // DM won the previous transfer
`else
      first_dm = 1'b1;
`endif
      second_addr = first_dm ? 32'h304 : 32'h300;
      mem_lat = 0;
      if (first_dm) begin
         exp_q.push_back('{1'b0, 1'b1, 1'b0, mem_val(32'h300)});
         exp_q.push_back('{1'b1, 1'b0, 1'b0, mem_val(32'h304)});
      end else begin
         exp_q.push_back('{1'b1, 1'b0, 1'b0, mem_val(32'h304)});
         exp_q.push_back('{1'b0, 1'b1, 1'b0, mem_val(32'h300)});
      end
      dm_we   = 1'b0;
      dm_addr = 32'h300;
      if_addr = 32'h304;
      dm_req  = 1'b1;
      if_req  = 1'b1;
      for (int k = 0; k < 2; k++) begin
         n = 0;
         while (obs_q.size() == 0 && n < 20) begin @(negedge clk); #1; n++; end
         if (first_dm ^ (k == 1)) dm_req = 1'b0; else if_req = 1'b0;
         total++;
         if (obs_q.size() == 0) begin
            bad++; exp_q.delete();
            $display("FAIL prio_done%0d: no completion seen", k);
         end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o !== e) begin
               bad++;
               $display("FAIL prio_done%0d: got ifr=%b dmr=%b rdata=%h required ifr=%b dmr=%b rdata=%h",
                        k, o.ifr, o.dmr, o.rdata, e.ifr, e.dmr, e.rdata);
            end
         end
         if (k == 0) begin
            total++;
            if (mem_req !== 1'b0) begin
               bad++;
               $display("FAIL prio_idle_gap: mem_req=%b required 0", mem_req);
            end
            @(negedge clk); #1;
            total++;
            if (mem_req !== 1'b1 || mem_addr !== second_addr) begin
               bad++;
               $display("FAIL prio_second_grant: mem_req=%b addr=%h required 1 %h",
                        mem_req, mem_addr, second_addr);
            end
         end
      end
      dm_req = 1'b0;
      if_req = 1'b0;
   endtask

   task automatic test_timeout();
      cpl_t o, e;
      int   n, busy;
      mem_never = 1'b1;
      exp_q.push_back('{1'b1, 1'b0, 1'b1, 32'h0});
      if_addr = 32'h44;
      if_req  = 1'b1;
      n = 0; busy = 0;
      while (obs_q.size() == 0 && n < 30) begin
         @(negedge clk); #1; n++;
         if (mem_req) busy++;
      end
      if_req    = 1'b0;
      mem_never = 1'b0;
      total++;
      if (obs_q.size() == 0) begin
         bad++; exp_q.delete();
         $display("FAIL timeout_abort: no bus_err/if_ready seen");
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o !== e) begin
            bad++;
            $display("FAIL timeout_abort: got ifr=%b dmr=%b err=%b rdata=%h required 1 0 1 00000000",
                     o.ifr, o.dmr, o.err, o.rdata);
         end
      end
      total++;
      if (busy != 4) begin
         bad++;
         $display("FAIL timeout_busy_cycles: got %0d required 4", busy);
      end
      total++;
      if (dm_rdata !== mem_val(32'h300)) begin
         bad++;
         $display("FAIL dm_rdata_hold: got %h required %h", dm_rdata, mem_val(32'h300));
      end
      @(negedge clk); #1;
      total++;
      if (mem_req !== 1'b0 || obs_q.size() != 0) begin
         bad++;
         $display("FAIL timeout_idle: mem_req=%b extra=%0d required 0 0", mem_req, obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_idle_ready();
      stray = 1'b1;
      repeat (3) begin @(negedge clk); #1; end
      stray = 1'b0;
      repeat (2) begin @(negedge clk); #1; end
      total++;
      if (obs_q.size() != 0 || mem_req !== 1'b0 || if_rdata !== 32'h0) begin
         bad++;
         $display("FAIL idle_ready_ignored: pulses=%0d mem_req=%b if_rdata=%h required 0 0 00000000",
                  obs_q.size(), mem_req, if_rdata);
         obs_q.delete();
      end
   endtask

   task automatic test_reset_mid();
      int n;
      mem_lat = 1;
      dm_we   = 1'b0;
      dm_addr = 32'h200;
      dm_req  = 1'b1;
      n = 0;
      while (!mem_req && n < 10) begin @(negedge clk); #1; n++; end
      @(negedge clk); #1;          // memory model raises mem_ready at this edge
      total++;
      if (mem_ready !== 1'b1 || mem_req !== 1'b1) begin
         bad++;
         $display("FAIL rst_setup: mem_ready=%b mem_req=%b required 1 1", mem_ready, mem_req);
      end
      #1;
      reset_n = 1'b0;
      dm_req  = 1'b0;
      #1;
      total++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_ready, dm_ready,
           if_rdata, dm_rdata, bus_err} !== '0) begin
         bad++;
         $display("FAIL rst_mid_outputs: mem_req=%b mem_addr=%h dm_rdata=%h dm_ready=%b required all 0",
                  mem_req, mem_addr, dm_rdata, dm_ready);
      end
      @(negedge clk); #1;
      reset_n = 1'b1;
      repeat (8) begin @(negedge clk); #1; end
      total++;
      if (obs_q.size() != 0 || mem_req !== 1'b0) begin
         bad++;
         $display("FAIL rst_no_ready: pulses=%0d mem_req=%b required 0 0", obs_q.size(), mem_req);
         obs_q.delete();
      end
   endtask

   task automatic test_addr_change();
      cpl_t o, e;
      int   n;
      mem_lat = 3;
      exp_q.push_back('{1'b1, 1'b0, 1'b0, 32'h0070_0393});
      if_addr = 32'h10;
      if_req  = 1'b1;
      @(posedge clk); #1;
      if_addr = 32'h20;
      n = 0;
      while (obs_q.size() == 0 && n < 20) begin
         if (mem_req) begin
            total++;
            if (mem_addr !== 32'h10) begin
               bad++;
               $display("FAIL addr_hold: mem_addr=%h required 00000010", mem_addr);
            end
         end
         @(negedge clk); #1; n++;
      end
      if_req = 1'b0;
      total++;
      if (obs_q.size() == 0) begin
         bad++; exp_q.delete();
         $display("FAIL addr_done: no completion seen");
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o !== e) begin
            bad++;
            $display("FAIL addr_done: got ifr=%b rdata=%h required ifr=%b rdata=%h",
                     o.ifr, o.rdata, e.ifr, e.rdata);
         end
      end
      @(negedge clk); #1;
   endtask

   task automatic test_back_to_back();
      cpl_t o, e;
      int   n;
      bit   use_dm;
      logic [31:0] a;
      for (int i = 0; i < 6; i++) begin
         use_dm  = 1'($urandom_range(0, 1));
         a       = 32'($urandom_range(0, 255)) << 2;
         mem_lat = $urandom_range(0, 2);
         if (use_dm) begin
            exp_q.push_back('{1'b0, 1'b1, 1'b0, mem_val(a)});
            dm_we = 1'($urandom_range(0, 1)); dm_addr = a; dm_wdata = $urandom; dm_be = 4'hF;
            dm_req = 1'b1;
         end else begin
            exp_q.push_back('{1'b1, 1'b0, 1'b0, mem_val(a)});
            if_addr = a;
            if_req  = 1'b1;
         end
         n = 0;
         while (obs_q.size() == 0 && n < 20) begin @(negedge clk); #1; n++; end
         dm_req = 1'b0;
         if_req = 1'b0;
         total++;
         if (obs_q.size() == 0) begin
            bad++; exp_q.delete();
            $display("FAIL b2b_%0d: no completion seen", i);
         end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o !== e) begin
               bad++;
               $display("FAIL b2b_%0d: got ifr=%b dmr=%b err=%b rdata=%h required ifr=%b dmr=%b err=%b rdata=%h",
                        i, o.ifr, o.dmr, o.err, o.rdata, e.ifr, e.dmr, e.err, e.rdata);
            end
         end
      end
      @(negedge clk); #1;
   endtask

   initial begin
      reset_n  = 1'b0;
      if_req   = 1'b0;
      if_addr  = '0;
      dm_req   = 1'b0;
      dm_we    = 1'b0;
      dm_addr  = '0;
      dm_wdata = '0;
      dm_be    = 4'h0;
      test_reset();
      test_if_only();
      test_dm_write();
      test_priority();
      test_timeout();
      test_idle_ready();
      test_reset_mid();
      test_addr_change();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1);
   end

endmodule
